// File: rtl/rpn_sequencer.sv
// rpn_sequencer: walks a stream of postfix tokens and drives a stack ALU
// with push/pop/add/multiply opcodes. It returns either the expression value
// with an overflow indication, or a malformed-expression status after
// emptying the ALU stack.
module rpn_sequencer #(
    parameter int N    = 32,
    parameter int SIZE = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_tok_valid,
    output logic                      o_tok_ready,
    input  logic [1:0]                i_tok_type,
    input  logic [N-1:0]              i_tok_value,
    output logic [2:0]                o_alu_opcode,
    output logic [N-1:0]              o_alu_data,
    input  logic [N-1:0]              i_alu_result,
    input  logic                      i_alu_overflow,
    output logic                      o_res_valid,
    input  logic                      i_res_ready,
    output logic [N-1:0]              o_res_value,
    output logic [1:0]                o_res_status,
    output logic [$clog2(SIZE+1)-1:0] o_depth,
    output logic                      o_busy
);

    localparam int DW = $clog2(SIZE + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(SIZE);

    localparam logic [1:0] TOK_NUM = 2'b00;
    localparam logic [1:0] TOK_ADD = 2'b01;
    localparam logic [1:0] TOK_MUL = 2'b10;
    localparam logic [1:0] TOK_END = 2'b11;

    localparam logic [2:0] OPC_NOP  = 3'b000;
    localparam logic [2:0] OPC_ADD  = 3'b100;
    localparam logic [2:0] OPC_MUL  = 3'b101;
    localparam logic [2:0] OPC_PUSH = 3'b110;
    localparam logic [2:0] OPC_POP  = 3'b111;

    localparam logic [1:0] STAT_OVF = 2'b01;
    localparam logic [1:0] STAT_BAD = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_PUSH, S_OP, S_CAP, S_POP1, S_POP2, S_REPUSH,
        S_FPOP, S_FCAP, S_DRAIN, S_FLUSH, S_RES
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_depth;
    logic [2:0]      r_alu_opcode;
    logic [N-1:0]    r_alu_data;
    logic [N-1:0]    r_acc;
    logic            r_ovf;
    logic            r_mal;
    logic [N-1:0]    r_res_value;
    logic [1:0]      r_res_status;
    logic [2:0]      w_opcode_next;
    logic            w_accept;
    logic            w_idle_accept;
    logic            w_bad_token;
    logic            w_mal_event;
    logic            w_enter_res;

    // Token acceptance and malformed-token classification in IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_bad_token = 1'b0;
        w_accept      = i_tok_valid & o_tok_ready;
        w_idle_accept = w_accept && (r_state == S_IDLE);
        unique case (i_tok_type)
            TOK_NUM:          w_bad_token = (r_depth >= DEPTH_MAX);
            TOK_ADD, TOK_MUL: w_bad_token = (r_depth < DW'(2));
            default:          w_bad_token = (r_depth != DW'(1));
        endcase
        w_mal_event = w_idle_accept && w_bad_token;
        w_enter_res = (w_next == S_RES) && (r_state != S_RES);
    end

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_idle_accept) begin
                    unique case (i_tok_type)
                        TOK_NUM:          w_next = w_bad_token ? S_DRAIN : S_PUSH;
                        TOK_ADD, TOK_MUL: w_next = w_bad_token ? S_DRAIN : S_OP;
                        default: begin
                            if (!w_bad_token)            w_next = S_FPOP;
                            else if (r_depth == '0)      w_next = S_RES;
                            else                         w_next = S_FLUSH;
                        end
                    endcase
                end
            end
            S_PUSH:   w_next = S_IDLE;
            S_OP:     w_next = S_CAP;
            S_CAP:    w_next = S_POP1;
            S_POP1:   w_next = S_POP2;
            S_POP2:   w_next = S_REPUSH;
            S_REPUSH: w_next = S_IDLE;
            S_FPOP:   w_next = S_FCAP;
            S_FCAP:   w_next = S_RES;
            S_DRAIN: begin
                if (w_accept && (i_tok_type == TOK_END))
                    w_next = (r_depth == '0) ? S_RES : S_FLUSH;
            end
            S_FLUSH:  if (r_depth <= DW'(1)) w_next = S_RES;
            S_RES:    if (i_res_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state, plus the opcode for the coming state.
    always_comb begin
        o_tok_ready   = (r_state == S_IDLE) || (r_state == S_DRAIN);
        o_busy        = (r_state != S_IDLE);
        o_res_valid   = (r_state == S_RES);
        w_opcode_next = OPC_NOP;
        unique case (w_next)
            S_PUSH, S_REPUSH:         w_opcode_next = OPC_PUSH;
            S_OP:                     w_opcode_next = (i_tok_type == TOK_MUL) ? OPC_MUL : OPC_ADD;
            S_POP1, S_POP2, S_FPOP,
            S_FLUSH:                  w_opcode_next = OPC_POP;
            default:                  w_opcode_next = OPC_NOP;
        endcase
    end

    // Datapath: ALU command registers, depth mirror, capture and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_alu_opcode <= OPC_NOP;
            r_alu_data   <= '0;
            r_depth      <= '0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            r_mal        <= 1'b0;
            r_res_value  <= '0;
            r_res_status <= 2'b00;
        end else begin
            r_alu_opcode <= w_opcode_next;

            if (w_next == S_PUSH)        r_alu_data <= i_tok_value;
            else if (w_next == S_REPUSH) r_alu_data <= r_acc;

            // Depth tracks the ALU stack: it moves on the edge where the ALU executes the opcode.
            unique case (r_state)
                S_PUSH, S_REPUSH:                r_depth <= r_depth + DW'(1);
                S_POP1, S_POP2, S_FPOP, S_FLUSH: r_depth <= r_depth - DW'(1);
                default:                         r_depth <= r_depth;
            endcase

            if (r_state == S_CAP) begin
                r_acc <= i_alu_result;
                r_ovf <= r_ovf | i_alu_overflow;
            end

            if (w_mal_event) r_mal <= 1'b1;

            // A malformed expression always reports zero; otherwise the popped value.
            if (w_enter_res) begin
                if (r_mal || w_mal_event) begin
                    r_res_value  <= '0;
                    r_res_status <= STAT_BAD;
                end else begin
                    r_res_value  <= i_alu_result;
                    r_res_status <= r_ovf ? STAT_OVF : 2'b00;
                end
            end

            if ((r_state == S_RES) && i_res_ready) begin
                r_ovf <= 1'b0;
                r_mal <= 1'b0;
            end
        end
    end

    assign o_alu_opcode = r_alu_opcode;
    assign o_alu_data   = r_alu_data;
    assign o_res_value  = r_res_value;
    assign o_res_status = r_res_status;
    assign o_depth      = r_depth;

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer: drives postfix token streams into rpn_sequencer, which
// talks to a behavioural stack ALU, and compares results against a
// queue-based postfix evaluator.
module tb_rpn_sequencer;

    localparam int N    = 32;
    localparam int SIZE = 16;
    localparam int DW   = $clog2(SIZE + 1);

    localparam logic [1:0] T_NUM = 2'b00;
    localparam logic [1:0] T_ADD = 2'b01;
    localparam logic [1:0] T_MUL = 2'b10;
    localparam logic [1:0] T_END = 2'b11;

    typedef struct {
        logic [1:0]   t;
        logic [N-1:0] v;
    } tok_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          i_tok_valid = 1'b0;
    logic          o_tok_ready;
    logic [1:0]    i_tok_type = 2'b00;
    logic [N-1:0]  i_tok_value = '0;
    logic [2:0]    o_alu_opcode;
    logic [N-1:0]  o_alu_data;
    logic [N-1:0]  alu_result;
    logic          alu_ovf;
    logic          o_res_valid;
    logic          i_res_ready = 1'b1;
    logic [N-1:0]  o_res_value;
    logic [1:0]    o_res_status;
    logic [DW-1:0] o_depth;
    logic          o_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    tok_t         expr[$];
    logic [N+1:0] res_q[$];
    logic [2:0]   op_q[$];

    rpn_sequencer #(.N(N), .SIZE(SIZE)) dut (
        .clock          (clock),
        .reset          (reset),
        .i_tok_valid    (i_tok_valid),
        .o_tok_ready    (o_tok_ready),
        .i_tok_type     (i_tok_type),
        .i_tok_value    (i_tok_value),
        .o_alu_opcode   (o_alu_opcode),
        .o_alu_data     (o_alu_data),
        .i_alu_result   (alu_result),
        .i_alu_overflow (alu_ovf),
        .o_res_valid    (o_res_valid),
        .i_res_ready    (i_res_ready),
        .o_res_value    (o_res_value),
        .o_res_status   (o_res_status),
        .o_depth        (o_depth),
        .o_busy         (o_busy)
    );

    always #5 clock = ~clock;

    function automatic longint wrap(input longint x);
        logic [N-1:0] lo;
        lo = x[N-1:0];
        return longint'($signed(lo));
    endfunction

    // Behavioural stack ALU: result reflects the opcode sampled on the previous edge.
    logic signed [N-1:0] alu_stk [SIZE];
    int     alu_sp;
    longint alu_top, alu_nxt, alu_sum, alu_prod;

    always_comb begin
        alu_top  = (alu_sp >= 1) ? longint'(alu_stk[alu_sp-1]) : 64'sd0;
        alu_nxt  = (alu_sp >= 2) ? longint'(alu_stk[alu_sp-2]) : 64'sd0;
        alu_sum  = alu_nxt + alu_top;
        alu_prod = alu_nxt * alu_top;
    end

    always @(posedge clock) begin
        if (reset) begin
            alu_sp     <= 0;
            alu_result <= '0;
            alu_ovf    <= 1'b0;
        end else begin
            case (o_alu_opcode)
                3'b110: if (alu_sp < SIZE) begin
                    alu_stk[alu_sp] <= o_alu_data;
                    alu_sp          <= alu_sp + 1;
                end
                3'b111: if (alu_sp > 0) begin
                    alu_result <= alu_top[N-1:0];
                    alu_sp     <= alu_sp - 1;
                    alu_ovf    <= 1'b0;
                end
                3'b100: begin
                    alu_result <= alu_sum[N-1:0];
                    alu_ovf    <= (wrap(alu_sum) != alu_sum);
                end
                3'b101: begin
                    alu_result <= alu_prod[N-1:0];
                    alu_ovf    <= (wrap(alu_prod) != alu_prod);
                end
                default: ;
            endcase
        end
    end

    // Observe result handshakes and every non-idle opcode issued to the ALU.
    always @(negedge clock) begin
        if (!reset) begin
            if (o_res_valid && i_res_ready) res_q.push_back({o_res_status, o_res_value});
            if (o_alu_opcode != 3'b000) op_q.push_back(o_alu_opcode);
        end
    end

    function automatic int count_pops();
        int c = 0;
        foreach (op_q[i]) if (op_q[i] == 3'b111) c++;
        return c;
    endfunction

    // Reference: evaluate the postfix token list with a value queue.
    task automatic ref_eval(output logic [N-1:0] ev, output logic [1:0] es);
        longint st[$];
        longint a, b, full, w, x;
        bit mal = 0, ovf = 0, done = 0;
        ev = '0;
        foreach (expr[i]) begin
            if (!done) begin
                case (expr[i].t)
                    T_NUM: begin
                        if (st.size() >= SIZE) begin mal = 1; done = 1; end
                        else st.push_back(longint'($signed(expr[i].v)));
                    end
                    T_ADD, T_MUL: begin
                        if (st.size() < 2) begin mal = 1; done = 1; end
                        else begin
                            b = st.pop_back();
                            a = st.pop_back();
                            full = (expr[i].t == T_ADD) ? a + b : a * b;
                            w = wrap(full);
                            if (w != full) ovf = 1;
                            st.push_back(w);
                        end
                    end
                    default: begin
                        if (st.size() != 1) mal = 1;
                        else begin x = st[0]; ev = x[N-1:0]; end
                        done = 1;
                    end
                endcase
            end
        end
        if (mal) begin ev = '0; es = 2'b10; end
        else es = {1'b0, ovf};
    endtask

    // Offer one token, called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_tok(input logic [1:0] t, input logic [N-1:0] v);
        int n = 0;
        i_tok_valid = 1'b1;
        i_tok_type  = t;
        i_tok_value = v;
        while (!o_tok_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!o_tok_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL send_tok: tok_ready stayed 0 for %0d cycles, required 1", n);
        end else begin
            @(negedge clock);
        end
        i_tok_valid = 1'b0;
    endtask

    task automatic run_expr();
        foreach (expr[i]) send_tok(expr[i].t, expr[i].v);
    endtask

    task automatic get_result(output bit got, output logic [N-1:0] v, output logic [1:0] s);
        logic [N+1:0] e;
        got = 0; v = '0; s = 2'b00;
        for (int i = 0; i < 400; i++) begin
            if (res_q.size() > 0) begin
                e = res_q.pop_front();
                {s, v} = e;
                got = 1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic add_tok(input logic [1:0] t, input logic [N-1:0] v);
        tok_t k;
        k.t = t; k.v = v;
        expr.push_back(k);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n_cmp++;
        if ({o_alu_opcode, o_alu_data, o_depth, o_res_valid, o_res_value, o_res_status, o_busy, o_tok_ready}
            !== {3'b000, {N{1'b0}}, {DW{1'b0}}, 1'b0, {N{1'b0}}, 2'b00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: opc=%b data=%h depth=%0d rv=%b val=%h st=%b busy=%b rdy=%b, required all 0 and rdy=1",
                     o_alu_opcode, o_alu_data, o_depth, o_res_valid, o_res_value, o_res_status, o_busy, o_tok_ready);
        end
    endtask

    task automatic test_add_basic();
        bit got; logic [N-1:0] v; logic [1:0] s;
        expr.delete(); res_q.delete(); op_q.delete();
        add_tok(T_NUM, 3); add_tok(T_NUM, 4); add_tok(T_ADD, 0); add_tok(T_END, 0);
        run_expr();
        get_result(got, v, s);
        n_cmp++;
        if (!got || v !== 32'd7 || s !== 2'b00) begin
            n_fail++;
            $display("FAIL add_basic: got=%0d value=%0d status=%b, required value 7 status 00", got, v, s);
        end
        repeat (4) @(negedge clock);
        n_cmp++;
        if (res_q.size() != 0 || o_depth !== '0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_single_pulse: extra=%0d depth=%0d busy=%b, required 0/0/0", res_q.size(), o_depth, o_busy);
        end
    endtask

    task automatic test_opcode_trace();
        bit got; logic [N-1:0] v; logic [1:0] s;
        logic [2:0] exp_ops[$] = '{3'b110, 3'b110, 3'b110, 3'b101, 3'b111, 3'b111, 3'b110,
                                   3'b100, 3'b111, 3'b111, 3'b110, 3'b111};
        expr.delete(); res_q.delete(); op_q.delete();
        add_tok(T_NUM, 2); add_tok(T_NUM, 3); add_tok(T_NUM, 4);
        add_tok(T_MUL, 0); add_tok(T_ADD, 0); add_tok(T_END, 0);
        run_expr();
        get_result(got, v, s);
        n_cmp++;
        if (!got || v !== 32'd14 || s !== 2'b00) begin
            n_fail++;
            $display("FAIL trace_result: got=%0d value=%0d status=%b, required 14 status 00", got, v, s);
        end
        n_cmp++;
        if (op_q != exp_ops) begin
            n_fail++;
            $display("FAIL opcode_trace: %0d non-idle opcodes seen, required %0d in order 110,110,110,101,111,111,110,100,111,111,110,111",
                     op_q.size(), exp_ops.size());
        end
    endtask

    task automatic test_overflow();
        bit got; logic [N-1:0] v; logic [1:0] s;
        expr.delete(); res_q.delete(); op_q.delete();
        add_tok(T_NUM, 32'h7FFF_FFFF); add_tok(T_NUM, 1); add_tok(T_ADD, 0); add_tok(T_END, 0);
        run_expr();
        get_result(got, v, s);
        n_cmp++;
        if (!got || v !== 32'h8000_0000 || s !== 2'b01) begin
            n_fail++;
            $display("FAIL overflow: got=%0d value=%h status=%b, required 80000000 status 01", got, v, s);
        end
    endtask

    task automatic test_drain();
        bit got; logic [N-1:0] v; logic [1:0] s;
        expr.delete(); res_q.delete(); op_q.delete();
        add_tok(T_NUM, 5); add_tok(T_ADD, 0); add_tok(T_NUM, 9); add_tok(T_END, 0);
        run_expr();
        get_result(got, v, s);
        n_cmp++;
        if (!got || v !== '0 || s !== 2'b10) begin
            n_fail++;
            $display("FAIL drain_result: got=%0d value=%0d status=%b, required 0 status 10", got, v, s);
        end
        n_cmp++;
        if (count_pops() != 1 || o_depth !== '0) begin
            n_fail++;
            $display("FAIL drain_pops: pops=%0d depth=%0d, required 1 pop and depth 0", count_pops(), o_depth);
        end
    endtask

    task automatic test_full_stack();
        bit got; logic [N-1:0] v; logic [1:0] s;
        expr.delete(); res_q.delete(); op_q.delete();
        for (int i = 1; i <= SIZE + 1; i++) add_tok(T_NUM, N'(i));
        add_tok(T_END, 0);
        run_expr();
        get_result(got, v, s);
        n_cmp++;
        if (!got || v !== '0 || s !== 2'b10) begin
            n_fail++;
            $display("FAIL full_result: got=%0d value=%0d status=%b, required 0 status 10", got, v, s);
        end
        n_cmp++;
        if (count_pops() != SIZE) begin
            n_fail++;
            $display("FAIL full_flush_pops: pops=%0d, required %0d", count_pops(), SIZE);
        end
        expr.delete(); res_q.delete(); op_q.delete();
        add_tok(T_NUM, 1); add_tok(T_NUM, 1); add_tok(T_ADD, 0); add_tok(T_END, 0);
        run_expr();
        get_result(got, v, s);
        n_cmp++;
        if (!got || v !== 32'd2 || s !== 2'b00) begin
            n_fail++;
            $display("FAIL after_full: got=%0d value=%0d status=%b, required 2 status 00", got, v, s);
        end
    endtask

    task automatic test_empty_end();
        bit got; logic [N-1:0] v; logic [1:0] s;
        expr.delete(); res_q.delete(); op_q.delete();
        add_tok(T_END, 0);
        run_expr();
        get_result(got, v, s);
        n_cmp++;
        if (!got || v !== '0 || s !== 2'b10 || count_pops() != 0) begin
            n_fail++;
            $display("FAIL empty_end: got=%0d value=%0d status=%b pops=%0d, required 0 status 10 pops 0",
                     got, v, s, count_pops());
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        expr.delete(); res_q.delete(); op_q.delete();
        i_res_ready = 1'b0;
        add_tok(T_NUM, 3); add_tok(T_NUM, 4); add_tok(T_ADD, 0); add_tok(T_END, 0);
        run_expr();
        while (!o_res_valid && n < 100) begin @(negedge clock); n++; end
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (o_res_valid !== 1'b1 || o_res_value !== 32'd7 || o_res_status !== 2'b00 || o_tok_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: rv=%b value=%0d status=%b rdy=%b, required 1/7/00/0",
                         c, o_res_valid, o_res_value, o_res_status, o_tok_ready);
            end
            @(negedge clock);
        end
        i_res_ready = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (o_res_valid !== 1'b0 || o_tok_ready !== 1'b1 || res_q.size() != 1) begin
            n_fail++;
            $display("FAIL backpressure_release: rv=%b rdy=%b handshakes=%0d, required 0/1/1",
                     o_res_valid, o_tok_ready, res_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit got; logic [N-1:0] v; logic [1:0] s;
        expr.delete(); res_q.delete(); op_q.delete();
        send_tok(T_NUM, 10);
        send_tok(T_NUM, 20);
        send_tok(T_ADD, 0);
        repeat (3) @(negedge clock);
        n_cmp++;
        if (o_alu_opcode !== 3'b111 || o_depth !== DW'(1) || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pop2_position: opc=%b depth=%0d busy=%b, required 111/1/1", o_alu_opcode, o_depth, o_busy);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_depth !== '0 || o_res_valid !== 1'b0 || o_tok_ready !== 1'b1 || o_alu_opcode !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b depth=%0d rv=%b rdy=%b opc=%b, required 0/0/0/1/000",
                     o_busy, o_depth, o_res_valid, o_tok_ready, o_alu_opcode);
        end
        repeat (10) @(negedge clock);
        n_cmp++;
        if (res_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_result: %0d results emitted, required 0", res_q.size());
        end
        expr.delete(); op_q.delete();
        add_tok(T_NUM, 6); add_tok(T_NUM, 7); add_tok(T_MUL, 0); add_tok(T_END, 0);
        run_expr();
        get_result(got, v, s);
        n_cmp++;
        if (!got || v !== 32'd42 || s !== 2'b00) begin
            n_fail++;
            $display("FAIL after_reset_mid: got=%0d value=%0d status=%b, required 42 status 00", got, v, s);
        end
    endtask

    task automatic test_random();
        bit got; logic [N-1:0] v, ev; logic [1:0] s, es;
        for (int e = 0; e < 40; e++) begin
            int len = $urandom_range(1, 14);
            int d = 0;
            expr.delete(); res_q.delete(); op_q.delete();
            for (int i = 0; i < len; i++) begin
                int r = $urandom_range(0, 99);
                if (d >= 2 && r < 45) begin
                    add_tok(($urandom_range(0, 1) == 1) ? T_MUL : T_ADD, $urandom);
                    d--;
                end else if (r < 92) begin
                    if ($urandom_range(0, 2) == 0) add_tok(T_NUM, $urandom);
                    else add_tok(T_NUM, $urandom_range(0, 40) - 20);
                    d++;
                end else begin
                    add_tok(T_ADD, 0);
                    if (d >= 2) d--;
                end
            end
            add_tok(T_END, 0);
            ref_eval(ev, es);
            run_expr();
            get_result(got, v, s);
            n_cmp++;
            if (!got || v !== ev || s !== es) begin
                n_fail++;
                $display("FAIL random[%0d]: got=%0d value=%h status=%b, required value %h status %b", e, got, v, s, ev, es);
            end
            repeat (2) @(negedge clock);
            n_cmp++;
            if (o_depth !== '0 || res_q.size() != 0) begin
                n_fail++;
                $display("FAIL random_idle[%0d]: depth=%0d extra=%0d, required 0/0", e, o_depth, res_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_opcode_trace();
        test_overflow();
        test_drain();
        test_full_stack();
        test_empty_end();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
